// File: rtl/program_sequencer.sv
`default_nettype none
// program_sequencer (rev 1.0): fetch/issue controller for the register-file + ALU datapath.
// Steps a PC through a loadable program memory, branches on the ALU flags sampled after each ALU word.
module program_sequencer #(
  parameter int         PROG_DEPTH  = 16,
  parameter int         ALU_LATENCY = 1,
  parameter logic [3:0] NOP_OP      = 4'hF,
  localparam int        PC_W        = $clog2(PROG_DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            load_en,
  input  logic [PC_W-1:0] load_addr,
  input  logic [11:0]     load_data,
  input  logic            zero_flag,
  input  logic            carry_flag,
  output logic [3:0]      instruction,
  output logic [1:0]      read_sel1,
  output logic [1:0]      read_sel2,
  output logic [1:0]      write_sel,
  output logic            issue,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted
);

  localparam int              CNT_W = $clog2(ALU_LATENCY + 1);
  localparam logic [CNT_W-1:0] LAT  = CNT_W'(ALU_LATENCY);

  localparam logic [1:0] CLS_ALU = 2'b00;
  localparam logic [1:0] CLS_BZ  = 2'b01;
  localparam logic [1:0] CLS_BC  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [PC_W-1:0]  pc_nxt;
  logic [9:0]       ir, ir_nxt;
  logic             saved_z, saved_z_nxt;
  logic             saved_c, saved_c_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic [11:0]      mem [PROG_DEPTH];
  logic [11:0]      fetch_word;
  logic [PC_W-1:0]  target;
  logic [PC_W-1:0]  pc_inc;
  logic             accepting;

  // Loads and starts are only honoured while the sequencer is parked.
  assign accepting  = (state == S_IDLE) || (state == S_HALTED);
  assign fetch_word = mem[pc];
  assign target     = fetch_word[PC_W-1:0];
  assign pc_inc     = pc + 1'b1;

  always_ff @(posedge clk) begin
    if (load_en && accepting) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      pc      <= '0;
      ir      <= '0;
      saved_z <= 1'b0;
      saved_c <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      ir      <= ir_nxt;
      saved_z <= saved_z_nxt;
      saved_c <= saved_c_nxt;
      cnt     <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    ir_nxt      = ir;
    saved_z_nxt = saved_z;
    saved_c_nxt = saved_c;
    cnt_nxt     = cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          pc_nxt    = '0;
          state_nxt = S_FETCH;
        end
      end
      S_HALTED: begin
        if (start) begin
          pc_nxt      = '0;
          saved_z_nxt = 1'b0;
          saved_c_nxt = 1'b0;
          state_nxt   = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_nxt = fetch_word[9:0];
        case (fetch_word[11:10])
          CLS_ALU: state_nxt = S_ISSUE;
          CLS_BZ:  pc_nxt = saved_z ? target : pc_inc;
          CLS_BC:  pc_nxt = saved_c ? target : pc_inc;
          default: begin
            if (fetch_word[9]) begin
              state_nxt = S_HALTED;
            end else begin
              pc_nxt = target;
            end
          end
        endcase
      end
      S_ISSUE: begin
        cnt_nxt   = LAT;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // Flags are only trusted once the full ALU latency has elapsed.
        if (cnt == CNT_W'(1)) begin
          saved_z_nxt = zero_flag;
          saved_c_nxt = carry_flag;
          pc_nxt      = pc_inc;
          state_nxt   = S_FETCH;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ALU fields stay on the bus through WAIT so the write-back lands on the right register.
  always_comb begin
    instruction = NOP_OP;
    read_sel1   = 2'b00;
    read_sel2   = 2'b00;
    write_sel   = 2'b00;
    if ((state == S_ISSUE) || (state == S_WAIT)) begin
      instruction = ir[9:6];
      read_sel1   = ir[5:4];
      read_sel2   = ir[3:2];
      write_sel   = ir[1:0];
    end
  end

  assign issue  = (state == S_ISSUE);
  assign busy   = (state == S_FETCH) || (state == S_ISSUE) || (state == S_WAIT);
  assign halted = (state == S_HALTED);

endmodule
`default_nettype wire
